// File: rtl/data_stack_if.sv
// Bus between a datapath and its hardware data stack: push/pop requests in,
// top/next-on-stack words, occupancy and sticky error flags out.
interface data_stack_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             clr_err;
  logic [WIDTH-1:0] tos_data;
  logic [WIDTH-1:0] nos_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, push_data, clr_err,
    input  tos_data, nos_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, clr_err,
    output tos_data, nos_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/data_stack.sv
// LIFO data stack with combinational top/next-on-stack taps, saturating count
// and sticky overflow/underflow flags. Push+pop together replaces the top word.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  data_stack_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             empty_w;
  logic             full_w;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nos_idx;
  op_e              op;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  // DEPTH is a power of two, so modular index arithmetic on the low bits
  // yields count-1 / count-2 without carrying the extra count bit.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign top_idx = count_q[AW-1:0] - AW'(1);
  assign nos_idx = count_q[AW-1:0] - AW'(2);

  always_comb begin
    op = OP_NONE;
    if (bus.push && bus.pop && !empty_w) op = OP_REPLACE;
    else if (bus.push)                   op = OP_PUSH;
    else if (bus.pop)                    op = OP_POP;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    count_d     = count_q;
    overflow_d  = bus.clr_err ? 1'b0 : overflow_q;
    underflow_d = bus.clr_err ? 1'b0 : underflow_q;
    wr_en       = 1'b0;
    wr_addr     = count_q[AW-1:0];

    unique case (op)
      OP_PUSH: begin
        if (full_w) begin
          overflow_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty_w) underflow_d = 1'b1;
        else         count_d     = count_q - CW'(1);
      end
      OP_REPLACE: begin
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the array has no reset; stale entries stay hidden because the read
  // taps force zero whenever the count says an entry is not valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= bus.push_data;
  end

  assign bus.tos_data  = empty_w            ? '0 : mem_q[top_idx];
  assign bus.nos_data  = (count_q < CW'(2)) ? '0 : mem_q[nos_idx];
  assign bus.count     = count_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: LIFO order, fill/overflow, underflow, replace,
// async reset and error-flag priority, against hand-computed values.
module tb_data_stack;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  data_stack_if #(.WIDTH(16), .CW(5)) bus ();

  data_stack #(.WIDTH(16), .DEPTH(16), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one request across a rising edge, then sample 1 time unit later.
  task automatic cycle(input logic push, input logic pop, input logic [15:0] data,
                       input logic clr);
    bus.push      = push;
    bus.pop       = pop;
    bus.push_data = data;
    bus.clr_err   = clr;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic do_push(input logic [15:0] data);
    cycle(1'b1, 1'b0, data, 1'b0);
  endtask

  task automatic do_pop();
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n         = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = 16'h0;
    bus.clr_err   = 1'b0;

    // Reset state, with a push held across an edge while in reset
    #2;
    bus.push      = 1'b1;
    bus.push_data = 16'hAAAA;
    @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_tos", 32'(bus.tos_data), 32'h0);
    check("rst_nos", 32'(bus.nos_data), 32'h0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_unf", 32'(bus.underflow), 32'd0);
    bus.push = 1'b0;
    #2;
    rst_n = 1'b1;

    // Basic LIFO
    do_push(16'h1111);
    check("lifo_tos1", 32'(bus.tos_data), 32'h1111);
    check("lifo_nos1", 32'(bus.nos_data), 32'h0);
    do_push(16'h2222);
    check("lifo_tos2", 32'(bus.tos_data), 32'h2222);
    check("lifo_nos2", 32'(bus.nos_data), 32'h1111);
    check("lifo_cnt2", 32'(bus.count), 32'd2);
    do_pop();
    check("lifo_pop_tos", 32'(bus.tos_data), 32'h1111);
    check("lifo_pop_nos", 32'(bus.nos_data), 32'h0);
    check("lifo_pop_cnt", 32'(bus.count), 32'd1);
    do_pop();
    check("lifo_empty", 32'(bus.empty), 32'd1);

    // Underflow, then clear
    do_pop();
    check("unf_cnt", 32'(bus.count), 32'd0);
    check("unf_tos", 32'(bus.tos_data), 32'h0);
    check("unf_flag", 32'(bus.underflow), 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("unf_clr", 32'(bus.underflow), 32'd0);

    // Push+pop on empty acts as a push and leaves underflow alone
    cycle(1'b1, 1'b1, 16'h0042, 1'b0);
    check("rep_empty_cnt", 32'(bus.count), 32'd1);
    check("rep_empty_tos", 32'(bus.tos_data), 32'h0042);
    check("rep_empty_unf", 32'(bus.underflow), 32'd0);
    do_pop();

    // Replace the top of a 3-deep stack
    do_push(16'h0001);
    do_push(16'h0002);
    do_push(16'h0003);
    check("rep_pre_tos", 32'(bus.tos_data), 32'h0003);
    cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
    check("rep_cnt", 32'(bus.count), 32'd3);
    check("rep_tos", 32'(bus.tos_data), 32'hBEEF);
    check("rep_nos", 32'(bus.nos_data), 32'h0002);
    check("rep_flags", 32'({bus.overflow, bus.underflow}), 32'd0);

    // Asynchronous reset between edges at count 5
    do_push(16'h0004);
    do_push(16'h0005);
    check("ar_pre_cnt", 32'(bus.count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cnt", 32'(bus.count), 32'd0);
    check("ar_empty", 32'(bus.empty), 32'd1);
    check("ar_tos", 32'(bus.tos_data), 32'h0);
    check("ar_nos", 32'(bus.nos_data), 32'h0);
    bus.push      = 1'b1;
    bus.push_data = 16'h7777;
    @(posedge clk);
    #1;
    check("ar_push_ign", 32'(bus.count), 32'd0);
    bus.push = 1'b0;
    #2;
    rst_n = 1'b1;

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) do_push(16'(i));
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_empty", 32'(bus.empty), 32'd0);
    check("fill_cnt", 32'(bus.count), 32'd16);
    check("fill_tos", 32'(bus.tos_data), 32'h000F);
    check("fill_nos", 32'(bus.nos_data), 32'h000E);
    do_push(16'hDEAD);
    check("ovf_cnt", 32'(bus.count), 32'd16);
    check("ovf_tos", 32'(bus.tos_data), 32'h000F);
    check("ovf_flag", 32'(bus.overflow), 32'd1);

    // Replace while full: no flag change, count held
    cycle(1'b1, 1'b1, 16'h5555, 1'b0);
    check("rep_full_cnt", 32'(bus.count), 32'd16);
    check("rep_full_tos", 32'(bus.tos_data), 32'h5555);
    check("rep_full_ovf", 32'(bus.overflow), 32'd1);

    // Setting event beats clear
    cycle(1'b1, 1'b0, 16'h1234, 1'b1);
    check("prio_ovf", 32'(bus.overflow), 32'd1);
    check("prio_cnt", 32'(bus.count), 32'd16);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("clr_ovf", 32'(bus.overflow), 32'd0);

    // Pop from full exposes the entry below
    do_pop();
    check("pop_full_cnt", 32'(bus.count), 32'd15);
    check("pop_full_flag", 32'(bus.full), 32'd0);
    check("pop_full_tos", 32'(bus.tos_data), 32'h000E);
    check("pop_full_nos", 32'(bus.nos_data), 32'h000D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of stack entries, a power of two ≥ 2.
REQ-003 Parameter CW, default 5: count width, equal to log2(DEPTH)+1.
REQ-004 Port clk  input  1: single clock; all state changes on rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port push  input  1: push request for the current cycle.
REQ-007 Port pop  input  1: pop request for the current cycle.
REQ-008 Port push_data  input  WIDTH: word to push, driven by the datapath 4:1 select output.
REQ-009 Port clr_err  input  1: synchronous clear of the sticky error flags.
REQ-010 Port tos_data  output  WIDTH: top-of-stack word, feeding the stack input of the datapath select.
REQ-011 Port nos_data  output  WIDTH: next-on-stack word, below the top, for ALU second operand.
REQ-012 Port count  output  CW: number of valid entries, 0..DEPTH.
REQ-013 Port empty  output  1: high when count == 0.
REQ-014 Port full  output  1: high when count == DEPTH.
REQ-015 Port overflow  output  1: sticky flag, set by a rejected push.
REQ-016 Port underflow  output  1: sticky flag, set by a rejected pop.

Function
REQ-017 Storage: DEPTH x WIDTH register array; entry index count-1 is the top of stack.
REQ-018 tos_data: combinational; mem[count-1] when count ≥ 1, else all zeros.
REQ-019 nos_data: combinational; mem[count-2] when count ≥ 2, else all zeros.
REQ-020 Push only, not full: write push_data to mem[count] and increment count; new word appears on tos_data the cycle after the edge.
REQ-021 Push only, full: no write, count unchanged, overflow set to 1.
REQ-022 Pop only, not empty: decrement count; the popped word is not cleared from the array.
REQ-023 Pop only, empty: count unchanged, underflow set to 1.
REQ-024 Push and pop together, not empty (replace): write push_data to mem[count-1], count unchanged, no flag change; this also applies when full.
REQ-025 Push and pop together, empty: behave as a push only (count becomes 1), underflow unchanged.
REQ-026 Neither push nor pop: state held.
REQ-027 clr_err high: overflow and underflow cleared to 0 at the edge; a simultaneous setting event takes priority, so the flag ends at 1.
REQ-028 count never wraps: it saturates at 0 and DEPTH under all input combinations.
REQ-029 empty and full are decoded combinationally from count and never both high.

Reset
REQ-030 rst_n low: count=0, overflow=0, underflow=0 immediately, independent of clk.
REQ-031 While rst_n is low: empty=1, full=0, tos_data=0, nos_data=0; push and pop are ignored.
REQ-032 Array contents are not reset; they are never observable because of the zero forcing in REQ-018 and REQ-019.
REQ-033 Reset asserted mid-operation discards all entries and any request in that cycle.
REQ-034 Operation resumes on the first rising edge after rst_n deasserts.

Verification
REQ-035 Basic LIFO: after reset, push 16'h1111 then 16'h2222, then pop once -> tos=16'h2222 and nos=16'h1111 with count=2; after the pop, tos=16'h1111, nos=0, count=1.
REQ-036 Fill and overflow: push 0x0000..0x000F (16 pushes) -> full=1, count=16, tos=0x000F; a 17th push of 0xDEAD -> count=16, tos=0x000F, overflow=1.
REQ-037 Underflow: pop with count=0 -> count=0, tos=0, underflow=1; then clr_err pulse -> underflow=0.
REQ-038 Replace: with count=3 and tos=0x0003, push+pop with 0xBEEF -> count=3, tos=0xBEEF, nos unchanged; push+pop on an empty stack with 0x0042 -> count=1, tos=0x0042, underflow=0.
REQ-039 Async reset: with count=5, drive rst_n low between clock edges -> count=0, empty=1, tos=0 before the next edge; a push held during reset has no effect.
REQ-040 Error priority: overflow=1, then clr_err asserted together with a push while full -> overflow stays 1.
